// File: rtl/fir_mac_arbiter.sv
// Round-robin arbiter sharing one FIR MAC datapath among NUM_REQ channels (IDLE -> MAC -> WRITE).
// Latency: req seen in IDLE at t -> mac_en t+1..t+MAC_CYCLES, res_wr_en/done at t+MAC_CYCLES+1 at the earliest.
// Backpressure: res_full holds WRITE with grant kept; FIR_ARB_PRIO_EN gives channel 0 strict priority.
module fir_mac_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAC_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       mac_en,
    output logic [$clog2(NUM_REQ)-1:0] mac_sel,
    output logic [7:0]                 mac_step,
    output logic                       mac_clr,
    input  logic                       res_full,
    output logic                       res_wr_en,
    output logic [NUM_REQ-1:0]         done
);
    localparam int SEL_W = $clog2(NUM_REQ);
`ifdef FIR_ARB_PRIO_EN
    localparam int FIRST_RR = 1;
`else
    localparam int FIRST_RR = 0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_q;
    logic [SEL_W-1:0]   sel_q, ptr_q, ptr_nxt, win_sel;
    logic [7:0]         cnt_q;
    logic               win_vld, cnt_last;

    assign cnt_last = (cnt_q == 8'(MAC_CYCLES - 1));

    // Round-robin search from the pointer; in priority builds index 0 is handled outside the ring.
    always_comb begin : p_pick
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_sel = '0;
`ifdef FIR_ARB_PRIO_EN
        if (req[0]) win_vld = 1'b1;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_vld && idx >= FIRST_RR && req[idx[SEL_W-1:0]]) begin
                win_vld = 1'b1;
                win_sel = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_nxt = (sel_q == SEL_W'(NUM_REQ - 1)) ? SEL_W'(FIRST_RR) : sel_q + 1'b1;
`ifdef FIR_ARB_PRIO_EN
        if (sel_q == '0) ptr_nxt = ptr_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        res_wr_en = 1'b0;
        case (state)
            IDLE:  if (win_vld) state_nxt = MAC;
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (cnt_q == 8'd0);
                if (cnt_last) state_nxt = WRITE;
            end
            WRITE: if (!res_full) begin
                res_wr_en = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    grant_q <= NUM_REQ'(1) << win_sel;
                    sel_q   <= win_sel;
                    cnt_q   <= '0;
                end
                MAC:  cnt_q <= cnt_last ? 8'd0 : cnt_q + 8'd1;
                WRITE: if (!res_full) begin
                    grant_q <= '0;
                    sel_q   <= '0;
                    ptr_q   <= ptr_nxt;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign grant    = grant_q;
    assign mac_sel  = sel_q;
    assign mac_step = (state == MAC) ? cnt_q : 8'd0;
    assign done     = res_wr_en ? grant_q : '0;
endmodule

// File: tb/tb_fir_mac_arbiter.sv
// Directed bench for fir_mac_arbiter (NUM_REQ=4, MAC_CYCLES=4) plus a randomized invariant sweep.
module tb_fir_mac_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic       res_full = 1'b0;
    logic [3:0] grant, done;
    logic       mac_en, mac_clr, res_wr_en;
    logic [1:0] mac_sel;
    logic [7:0] mac_step;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    logic [3:0] req_cur = '0;

    fir_mac_arbiter #(.NUM_REQ(4), .MAC_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .req(req), .grant(grant), .mac_en(mac_en),
        .mac_sel(mac_sel), .mac_step(mac_step), .mac_clr(mac_clr), .res_full(res_full),
        .res_wr_en(res_wr_en), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 2ns after it.
    task automatic cyc(input logic [3:0] r, input logic f, input logic rs);
        @(posedge clock);
        #1;
        req = r; res_full = f; reset = rs;
        #1;
        cyc_n++;
    endtask

    task automatic all_zero(input string tag);
        check(tag, int'({grant, done, mac_sel, mac_step, mac_en, mac_clr, res_wr_en}), 0);
    endtask

    task automatic wait_done(output logic [3:0] d, output int at);
        d = '0; at = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(req_cur, 1'b0, 1'b0);
            if (done != 0) begin d = done; at = cyc_n; return; end
        end
        check("done_timeout", 0, 1);
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    logic [3:0] d;
    int at, last_at, mac_cnt;
    int exp_own1 [5];
    int exp_own2 [4] = '{1, 2, 3, 1};

    initial begin
`ifdef FIR_ARB_PRIO_EN
        exp_own1 = '{0, 0, 0, 0, 0};
`else
        exp_own1 = '{0, 1, 2, 3, 0};
`endif
        // Reset state
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0);
        all_zero("reset_state");

        // Single request on channel 2, cycle-by-cycle
        cyc(4'b0100, 1'b0, 1'b0);
        check("a_c0_grant", grant, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc(4'b0000, 1'b0, 1'b0);
            check("a_grant", grant, 4'b0100);
            check("a_sel", mac_sel, 2);
            check("a_mac_en", mac_en, 1);
            check("a_step", mac_step, c - 1);
            check("a_clr", mac_clr, (c == 1) ? 1 : 0);
            check("a_wr", {res_wr_en, done}, 0);
        end
        cyc(4'b0000, 1'b0, 1'b0);
        check("a_c5_grant", grant, 4'b0100);
        check("a_c5_mac_en", mac_en, 0);
        check("a_c5_wr", res_wr_en, 1);
        check("a_c5_done", done, 4'b0100);
        cyc(4'b0000, 1'b0, 1'b0);
        all_zero("a_c6_idle");

        // res_full stalls WRITE over cycles 5-7
        cyc(4'b0001, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) cyc(4'b0000, 1'b0, 1'b0);
        check("b_c4_step", mac_step, 3);
        for (int c = 5; c <= 7; c++) begin
            cyc(4'b0000, 1'b1, 1'b0);
            check("b_hold_grant", grant, 4'b0001);
            check("b_hold_out", {mac_en, res_wr_en, done}, 0);
        end
        cyc(4'b0000, 1'b0, 1'b0);
        check("b_c8_wr", res_wr_en, 1);
        check("b_c8_done", done, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b0);
        check("b_c9_grant", grant, 0);

        // Reset during MAC abandons the transaction
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("c_grant", grant, 4'b1000);
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1);
        for (int c = 4; c <= 10; c++) begin
            cyc(4'b0000, 1'b0, 1'b0);
            all_zero("c_after_reset");
        end
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("c_new_grant", grant, 4'b0010);
        check("c_new_sel", mac_sel, 1);
        req_cur = '0;
        wait_done(d, at);
        check("c_new_done", d, 4'b0010);

        // All channels held: ownership order and 6-cycle cadence
        cyc(4'b0000, 1'b0, 1'b1);
        req_cur = 4'b1111;
        last_at = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(d, at);
            check("d_owner", oh2idx(d), exp_own1[k]);
            if (k > 0) check("d_period", at - last_at, 6);
            last_at = at;
        end
        req_cur = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, at);
            check("d_owner_no0", oh2idx(d), exp_own2[k]);
            check("d_period2", at - last_at, 6);
            last_at = at;
        end

        // Random req / res_full: structural invariants
        cyc(4'b0000, 1'b0, 1'b1);
        mac_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
            check("r_onehot", {$onehot0(grant), $onehot0(done), !(mac_en && res_wr_en)}, 3'b111);
            check("r_full_blk", res_wr_en & res_full, 0);
            if (grant != 0) check("r_sel", mac_sel, oh2idx(grant));
            if (mac_en) begin
                check("r_clr", mac_clr, (mac_cnt == 0) ? 1 : 0);
                check("r_step", mac_step, mac_cnt);
                mac_cnt++;
            end
            if (res_wr_en) begin
                check("r_mac_len", mac_cnt, 4);
                check("r_done", done, grant);
                mac_cnt = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
